dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the processor's load/store port.
- Accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns one response over a second valid/ready handshake.
- Supports RV64 access sizes: byte, half, word and double, with sign or zero extension on loads.
- Sits beside Procesador_RISC_V as its data memory, and is used as the bus-functional memory in processor benches.

---
 rtl/riscv_mem_pkg.sv | 22 ++
 rtl/dmem_load_align.sv | 36 +++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory port: access sizes, responder
// states and word geometry.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int unsigned bytes_per_word(input int unsigned bits);
      return bits / 8;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data aligner: selects the addressed bytes of a memory word and
// sign- or zero-extends them to the full word width.
module dmem_load_align
   import riscv_mem_pkg::*;
#(
   parameter int unsigned Bits = 64
) (
   input  logic [Bits-1:0]                          word,
   input  logic [$clog2(bytes_per_word(Bits))-1:0]  addr_lo,
   input  size_e                                    size,
   input  logic                                     uns,
   output logic [Bits-1:0]                          result_c
);

   localparam int unsigned OFFW = $clog2(bytes_per_word(Bits));

   logic [Bits-1:0]   shifted;
   logic [OFFW+2:0]   shamt;

   assign shamt   = {addr_lo, 3'b000};
   assign shifted = word >> shamt;

   always_comb begin
      result_c = shifted;
      case (size)
         SZ_B: result_c = uns ? Bits'(shifted[7:0])
                              : {{(Bits-8){shifted[7]}}, shifted[7:0]};
         SZ_H: result_c = uns ? Bits'(shifted[15:0])
                              : {{(Bits-16){shifted[15]}}, shifted[15:0]};
         SZ_W: result_c = uns ? Bits'(shifted[31:0])
                              : {{(Bits-32){shifted[31]}}, shifted[31:0]};
         default: result_c = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, fixed
// programmable latency, then one response; byte-lane stores, extended loads.
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int unsigned Bits    = 64,
   parameter int unsigned MemSize = 16,
   parameter int unsigned Latency = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [Bits-1:0] req_addr,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [Bits-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [Bits-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned BPW  = bytes_per_word(Bits);
   localparam int unsigned OFFW = $clog2(BPW);
   localparam int unsigned IDXW = $clog2(MemSize);
   localparam int unsigned CNTW = 4;
   localparam logic [Bits-1:0] ADDR_LIMIT = Bits'(MemSize * BPW);

   state_e            state, state_d;
   logic [CNTW-1:0]   cnt, cnt_d;

   logic              we_q;
   logic [Bits-1:0]   addr_q;
   size_e             size_q;
   logic              uns_q;
   logic [Bits-1:0]   wdata_q;

   logic [Bits-1:0]   mem [MemSize];

   logic              accept_c, commit_c, err_c;
   logic [OFFW-1:0]   off_c, align_m1_c;
   logic [IDXW-1:0]   idx_c;
   logic [OFFW+2:0]   shamt_c;
   logic [Bits-1:0]   word_c, lane_mask_c, wmask_c, wword_c, ld_data_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: if (req_valid) begin
            state_d = BUSY;
            cnt_d   = CNTW'(Latency);
         end
         BUSY: if (cnt != '0) cnt_d = cnt - CNTW'(1);
               else           state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign accept_c = (state == IDLE) && req_valid;
   assign commit_c = (state == BUSY) && (cnt == '0);

   // Alignment mask wraps to all-ones for a full-word access
   assign off_c      = addr_q[OFFW-1:0];
   assign align_m1_c = (OFFW'(1) << size_q) - OFFW'(1);
   assign err_c      = ((off_c & align_m1_c) != '0) || (addr_q >= ADDR_LIMIT);
   assign idx_c      = addr_q[OFFW +: IDXW];
   assign word_c     = mem[idx_c];
   assign shamt_c    = {off_c, 3'b000};

   always_comb begin
      lane_mask_c = '1;
      case (size_q)
         SZ_B:    lane_mask_c = Bits'(8'hFF);
         SZ_H:    lane_mask_c = Bits'(16'hFFFF);
         SZ_W:    lane_mask_c = Bits'(32'hFFFF_FFFF);
         default: lane_mask_c = '1;
      endcase
   end

   assign wmask_c = lane_mask_c << shamt_c;
   assign wword_c = (word_c & ~wmask_c) | ((wdata_q & lane_mask_c) << shamt_c);

   dmem_load_align #(.Bits(Bits)) u_align (
      .word     (word_c),
      .addr_lo  (off_c),
      .size     (size_q),
      .uns      (uns_q),
      .result_c (ld_data_c)
   );

   // Registered outputs, request capture and storage
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         size_q    <= SZ_B;
         uns_q     <= 1'b0;
         wdata_q   <= '0;
         for (int i = 0; i < MemSize; i++) mem[i] <= '0;
      end else begin
         req_ready <= (state_d == IDLE);
         rsp_valid <= (state_d == RESP);
         if (accept_c) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
         end
         if (commit_c) begin
            rsp_err   <= err_c;
            rsp_rdata <= (err_c || we_q) ? '0 : ld_data_c;
            if (we_q && !err_c) mem[idx_c] <= wword_c;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model checked every cycle,
// plus directed transactions with hand-computed expected results.
module tb_dmem_responder;
   import riscv_mem_pkg::*;

   localparam int unsigned LAT  = 2;
   localparam int unsigned MEMB = 128;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic        rsp_ready = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0, rsp_rdata;
   logic [1:0]  req_size = 2'd0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_responder #(.Bits(64), .MemSize(16), .Latency(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory and a transaction timeline
   logic [7:0]  mb [MEMB];
   bit          live = 0;
   bit          pending = 0;
   int          wait_n = 0;
   logic [63:0] exp_rd = '0, nxt_rd = '0;
   logic        exp_err = 1'b0, nxt_err = 1'b0;

   function void model_access(input logic we, input logic [63:0] addr,
                              input logic [1:0] sz, input logic uns,
                              input logic [63:0] wd);
      int unsigned n;
      logic [63:0] v;
      n = 1 << sz;
      nxt_err = ((addr % 64'(n)) != 0) || (addr >= 64'(MEMB));
      nxt_rd  = '0;
      if (!nxt_err) begin
         if (we) begin
            for (int k = 0; k < int'(n); k++) mb[int'(addr) + k] = wd[8*k +: 8];
         end else begin
            v = '0;
            for (int k = 0; k < int'(n); k++) v[8*k +: 8] = mb[int'(addr) + k];
            if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            nxt_rd = v;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(MEMB); i++) mb[i] = 8'h00;
         pending = 0;
         wait_n  = 0;
         exp_rd  = '0;
         exp_err = 1'b0;
         live    = 1;
      end else if (live) begin
         if (!pending) begin
            if (req_valid) begin
               model_access(req_we, req_addr, req_size, req_unsigned, req_wdata);
               pending = 1;
               wait_n  = LAT + 1;
            end
         end else if (wait_n > 0) begin
            wait_n--;
            if (wait_n == 0) begin
               exp_rd  = nxt_rd;
               exp_err = nxt_err;
            end
         end else if (rsp_ready) begin
            pending = 0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (live) begin
         chk("req_ready", 64'(req_ready), 64'(!pending));
         chk("rsp_valid", 64'(rsp_valid), 64'(pending && wait_n == 0));
         chk("rsp_rdata", rsp_rdata, exp_rd);
         chk("rsp_err",   64'(rsp_err), 64'(exp_err));
      end
   end

   task automatic xact(input logic we, input logic [63:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] wd, input int stall,
                       output logic [63:0] rd, output logic er, output int lat);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
      req_unsigned = uns; req_wdata = wd;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("accept", 64'(req_ready), 64'd1);
      @(posedge clk);
      lat = 0;
      while (1) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid || lat >= 50) break;
         @(posedge clk);
         lat++;
      end
      chk("rsp_seen", 64'(rsp_valid), 64'd1);
      repeat (stall) @(negedge clk);
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("ready_after_hs", 64'(req_ready), 64'd1);
   endtask

   logic [63:0] rd;
   logic        er;
   int          lat;

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      xact(0, 64'h0, 2'd3, 0, 0, 0, rd, er, lat);
      chk("load_d0_after_rst", rd, 64'd0);

      xact(1, 64'h8, 2'd3, 0, 64'h1122334455667788, 0, rd, er, lat);
      chk("store_d_latency", 64'(lat), 64'(LAT + 1));
      chk("store_d_err", 64'(er), 64'd0);
      chk("store_d_rdata", rd, 64'd0);
      xact(0, 64'h8, 2'd3, 0, 0, 0, rd, er, lat);
      chk("load_d8", rd, 64'h1122334455667788);

      xact(1, 64'h9, 2'd0, 0, 64'h80, 0, rd, er, lat);
      xact(0, 64'h9, 2'd0, 0, 0, 0, rd, er, lat);
      chk("load_b9_signed", rd, 64'hFFFFFFFFFFFFFF80);
      xact(0, 64'h9, 2'd0, 1, 0, 0, rd, er, lat);
      chk("load_b9_unsigned", rd, 64'h80);
      xact(0, 64'h8, 2'd3, 0, 0, 0, rd, er, lat);
      chk("load_d8_merged", rd, 64'h1122334455668088);

      xact(0, 64'h6, 2'd2, 0, 0, 0, rd, er, lat);
      chk("misaligned_w_err", 64'(er), 64'd1);
      chk("misaligned_w_rdata", rd, 64'd0);
      xact(1, 64'h80, 2'd3, 0, 64'hCAFEF00DCAFEF00D, 0, rd, er, lat);
      chk("oor_store_err", 64'(er), 64'd1);
      xact(0, 64'h0, 2'd3, 0, 0, 0, rd, er, lat);
      chk("no_alias_load_d0", rd, 64'd0);

      xact(0, 64'h8, 2'd3, 0, 0, 5, rd, er, lat);
      chk("backpressure_rdata", rd, 64'h1122334455668088);

      xact(1, 64'h14, 2'd2, 0, 64'hFFFFFFFF80000000, 0, rd, er, lat);
      xact(0, 64'h14, 2'd2, 0, 0, 0, rd, er, lat);
      chk("load_w14_signed", rd, 64'hFFFFFFFF80000000);
      xact(0, 64'h16, 2'd1, 1, 0, 0, rd, er, lat);
      chk("load_h16_unsigned", rd, 64'h8000);
      xact(0, 64'h13, 2'd1, 0, 0, 0, rd, er, lat);
      chk("misaligned_h_err", 64'(er), 64'd1);
      xact(1, 64'h7F, 2'd0, 0, 64'h5A, 0, rd, er, lat);
      chk("last_byte_store_err", 64'(er), 64'd0);
      xact(0, 64'h78, 2'd3, 0, 0, 0, rd, er, lat);
      chk("load_d78", rd, 64'h5A00000000000000);
      xact(0, 64'h80, 2'd0, 0, 0, 0, rd, er, lat);
      chk("oor_byte_err", 64'(er), 64'd1);

      // Reset while the store is still waiting out its latency
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h10; req_size = 2'd3;
      req_unsigned = 1'b0; req_wdata = 64'hDEAD;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_req_ready", 64'(req_ready), 64'd1);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 64'd0);
      chk("midrst_rsp_err", 64'(rsp_err), 64'd0);
      xact(0, 64'h10, 2'd3, 0, 0, 0, rd, er, lat);
      chk("midrst_load_d10", rd, 64'd0);
      xact(0, 64'h8, 2'd3, 0, 0, 0, rd, er, lat);
      chk("midrst_mem_cleared", rd, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
